// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_W           = 12;
  localparam int unsigned OFFSET_W       = PC_W;
  localparam int unsigned PROG_DEPTH_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Relative branch target: PC plus signed offset, with program-memory range check.
module pc_target_adder
  import pc_pkg::*;
#(
  parameter int unsigned D          = PC_W,
  parameter int unsigned PROG_DEPTH = PROG_DEPTH_DEF
) (
  input  logic [D-1:0] pc,
  input  logic [D-1:0] offset,
  output logic [D-1:0] next_pc_c,
  output logic         in_range_c
);

  localparam logic [D-1:0] LAST_ADDR = D'(PROG_DEPTH - 1);

  logic [D:0] sum_c;

  // A set top bit means the sum is either negative or at/above 2^D; both are illegal.
  always_comb begin
    sum_c      = {1'b0, pc} + {offset[D-1], offset};
    next_pc_c  = sum_c[D-1:0];
    in_range_c = ~sum_c[D] && (sum_c[D-1:0] <= LAST_ADDR);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/run/done control, stall hold, relative branches.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned D          = PC_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned PROG_DEPTH = PROG_DEPTH_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic         branch,
  input  logic [D-1:0] offset,
  input  logic         halt,
  input  logic         stall,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         done,
  output logic         range_err
);

  localparam logic [D-1:0] START_PC  = D'(START_ADDR);
  localparam logic [D-1:0] LAST_ADDR = D'(PROG_DEPTH - 1);

  state_e       state, state_nxt;
  logic [D-1:0] pc_nxt;
  logic         fetch_valid_nxt;
  logic         done_nxt;
  logic         range_err_nxt;
  logic [D-1:0] target_c;
  logic         in_range_c;

  pc_target_adder #(
    .D          (D),
    .PROG_DEPTH (PROG_DEPTH)
  ) u_target_adder (
    .pc         (prog_ctr),
    .offset     (offset),
    .next_pc_c  (target_c),
    .in_range_c (in_range_c)
  );

  // State and output registers; everything visible outside is a flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      prog_ctr    <= START_PC;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      prog_ctr    <= pc_nxt;
      fetch_valid <= fetch_valid_nxt;
      done        <= done_nxt;
      range_err   <= range_err_nxt;
    end
  end

  // Next state and next outputs; priority in RUN is stall > halt > branch > increment.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = prog_ctr;
    range_err_nxt = range_err;

    case (state)
      IDLE, DONE: begin
        if (state == IDLE) begin
          pc_nxt = START_PC;
        end
        if (start) begin
          state_nxt     = RUN;
          pc_nxt        = START_PC;
          range_err_nxt = 1'b0;
        end
      end
      RUN: begin
        if (stall) begin
          state_nxt = RUN;
        end else if (halt) begin
          state_nxt = DONE;
        end else if (branch) begin
          if (in_range_c) begin
            pc_nxt = target_c;
          end else begin
            range_err_nxt = 1'b1;
            state_nxt     = DONE;
          end
        end else if (prog_ctr == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          pc_nxt = prog_ctr + D'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = START_PC;
      end
    endcase

    fetch_valid_nxt = (state_nxt == RUN);
    done_nxt        = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences, randomized model check.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        branch = 1'b0;
  logic [11:0] offset = 12'h000;
  logic        halt = 1'b0;
  logic        stall = 1'b0;

  logic [11:0] pc_a, pc_b;
  logic        fv_a, fv_b, done_a, done_b, re_a, re_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(.D(12), .START_ADDR(0), .PROG_DEPTH(4096)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .branch(branch), .offset(offset),
    .halt(halt), .stall(stall), .prog_ctr(pc_a), .fetch_valid(fv_a), .done(done_a),
    .range_err(re_a)
  );

  pc_sequencer #(.D(12), .START_ADDR(0), .PROG_DEPTH(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .branch(branch), .offset(offset),
    .halt(halt), .stall(stall), .prog_ctr(pc_b), .fetch_valid(fv_b), .done(done_b),
    .range_err(re_b)
  );

  typedef struct {
    bit          st;
    bit          br;
    logic [11:0] off;
    bit          hl;
    bit          sl;
    int          exp_pc;
    bit          exp_fv;
    bit          exp_done;
    bit          exp_re;
  } vec_t;

  typedef struct {
    int pc;
    bit run;
    bit dn;
    bit re;
  } model_t;

  vec_t   vecs[$];
  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.pc = 0; m.run = 1'b0; m.dn = 1'b0; m.re = 1'b0;
    return m;
  endfunction

  // Behavioural rule set: integer PC, integer target, plain range test.
  function automatic model_t model_step(model_t m, int depth, bit st, bit br,
                                        logic [11:0] off, bit hl, bit sl);
    model_t r = m;
    int     soff = int'(off);
    int     tgt;
    if (off[11]) soff = soff - 4096;
    if (!m.run) begin
      if (st) begin
        r.pc = 0; r.run = 1'b1; r.dn = 1'b0; r.re = 1'b0;
      end
    end else if (sl) begin
      r = m;
    end else if (hl) begin
      r.run = 1'b0; r.dn = 1'b1;
    end else if (br) begin
      tgt = m.pc + soff;
      if (tgt >= 0 && tgt < depth) r.pc = tgt;
      else begin
        r.re = 1'b1; r.run = 1'b0; r.dn = 1'b1;
      end
    end else if (m.pc == depth - 1) begin
      r.run = 1'b0; r.dn = 1'b1;
    end else begin
      r.pc = m.pc + 1;
    end
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input bit st, input bit br, input logic [11:0] off,
                         input bit hl, input bit sl, input int epc,
                         input bit efv, input bit edn, input bit ere);
    vec_t v;
    v.st = st; v.br = br; v.off = off; v.hl = hl; v.sl = sl;
    v.exp_pc = epc; v.exp_fv = efv; v.exp_done = edn; v.exp_re = ere;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it in, then advance both models.
  task automatic apply(input bit st, input bit br, input logic [11:0] off,
                       input bit hl, input bit sl);
    start = st; branch = br; offset = off; halt = hl; stall = sl;
    @(posedge Clk);
    #1;
    ma = model_step(ma, 4096, st, br, off, hl, sl);
    mb = model_step(mb, 16, st, br, off, hl, sl);
  endtask

  task automatic cmp_models(input string tag);
    check({tag, " a.pc"},   int'(pc_a),   ma.pc);
    check({tag, " a.fv"},   int'(fv_a),   int'(ma.run));
    check({tag, " a.done"}, int'(done_a), int'(ma.dn));
    check({tag, " a.rerr"}, int'(re_a),   int'(ma.re));
    check({tag, " b.pc"},   int'(pc_b),   mb.pc);
    check({tag, " b.fv"},   int'(fv_b),   int'(mb.run));
    check({tag, " b.done"}, int'(done_b), int'(mb.dn));
    check({tag, " b.rerr"}, int'(re_b),   int'(mb.re));
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();

    // Directed table for the 4096-deep instance.
    add_vec(1, 0, 12'h000, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) add_vec(0, 0, 12'h000, 0, 0, k, 1, 0, 0);
    add_vec(0, 1, 12'hFFB, 0, 0, 5, 1, 0, 0);
    add_vec(0, 1, 12'h014, 0, 0, 25, 1, 0, 0);
    add_vec(0, 1, 12'h000, 0, 0, 25, 1, 0, 0);
    add_vec(1, 0, 12'h000, 0, 0, 26, 1, 0, 0);
    add_vec(0, 0, 12'h000, 1, 0, 26, 0, 1, 0);
    add_vec(1, 0, 12'h000, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) add_vec(0, 0, 12'h000, 0, 0, k, 1, 0, 0);
    add_vec(0, 1, 12'hFFB, 0, 0, 3, 0, 1, 1);
    add_vec(0, 0, 12'h000, 0, 0, 3, 0, 1, 1);
    add_vec(1, 0, 12'h000, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) add_vec(0, 0, 12'h000, 0, 0, k, 1, 0, 0);
    for (int k = 0; k < 3; k++) add_vec(0, 1, 12'h014, 1, 1, 7, 1, 0, 0);
    add_vec(0, 1, 12'h014, 1, 0, 7, 0, 1, 0);
    add_vec(0, 0, 12'h000, 0, 0, 7, 0, 1, 0);

    // Reset state while Reset_n is held low.
    #2;
    check("reset pc",   int'(pc_a),   0);
    check("reset fv",   int'(fv_a),   0);
    check("reset done", int'(done_a), 0);
    check("reset rerr", int'(re_a),   0);
    #10 Reset_n = 1'b1;
    apply(0, 0, 12'h000, 0, 0);
    check("idle pc", int'(pc_a), 0);
    check("idle fv", int'(fv_a), 0);

    foreach (vecs[i]) begin
      apply(vecs[i].st, vecs[i].br, vecs[i].off, vecs[i].hl, vecs[i].sl);
      check($sformatf("vec%0d pc", i),   int'(pc_a),   vecs[i].exp_pc);
      check($sformatf("vec%0d fv", i),   int'(fv_a),   int'(vecs[i].exp_fv));
      check($sformatf("vec%0d done", i), int'(done_a), int'(vecs[i].exp_done));
      check($sformatf("vec%0d rerr", i), int'(re_a),   int'(vecs[i].exp_re));
    end

    // Small program: run off the end without wrapping, then branch past the end.
    apply(1, 0, 12'h000, 0, 0);
    check("d16 start pc", int'(pc_b), 0);
    for (int k = 1; k <= 15; k++) begin
      apply(0, 0, 12'h000, 0, 0);
      check($sformatf("d16 inc%0d pc", k), int'(pc_b), k);
      check($sformatf("d16 inc%0d fv", k), int'(fv_b), 1);
    end
    apply(0, 0, 12'h000, 0, 0);
    check("d16 end pc",   int'(pc_b),   15);
    check("d16 end done", int'(done_b), 1);
    check("d16 end fv",   int'(fv_b),   0);
    check("d16 end rerr", int'(re_b),   0);
    cmp_models("d16end");
    apply(1, 0, 12'h000, 0, 0);
    for (int k = 1; k <= 15; k++) apply(0, 0, 12'h000, 0, 0);
    check("d16 rerun pc", int'(pc_b), 15);
    apply(0, 1, 12'h001, 0, 0);
    check("d16 br+1 pc",   int'(pc_b),   15);
    check("d16 br+1 rerr", int'(re_b),   1);
    check("d16 br+1 done", int'(done_b), 1);
    cmp_models("d16br");

    // Asynchronous reset mid-run at PC 9.
    apply(0, 0, 12'h000, 1, 0);
    apply(1, 0, 12'h000, 0, 0);
    for (int k = 1; k <= 9; k++) apply(0, 0, 12'h000, 0, 0);
    check("pre-rst pc", int'(pc_a), 9);
    #1 Reset_n = 1'b0;
    #1;
    check("async rst pc",   int'(pc_a),   0);
    check("async rst fv",   int'(fv_a),   0);
    check("async rst done", int'(done_a), 0);
    check("async rst rerr", int'(re_a),   0);
    #1 Reset_n = 1'b1;
    ma = model_reset();
    mb = model_reset();
    apply(0, 0, 12'h000, 0, 0);
    check("post-rst idle pc", int'(pc_a), 0);
    check("post-rst idle fv", int'(fv_a), 0);
    apply(1, 0, 12'h000, 0, 0);
    check("post-rst start fv", int'(fv_a), 1);
    apply(0, 0, 12'h000, 0, 0);
    check("post-rst inc pc", int'(pc_a), 1);

    // Randomized traffic against the behavioural model.
    for (int c = 0; c < 600; c++) begin
      bit          r_st, r_br, r_hl, r_sl;
      logic [11:0] r_off;
      r_st = ($urandom % 12) == 0;
      r_br = ($urandom % 4) == 0;
      r_hl = ($urandom % 40) == 0;
      r_sl = ($urandom % 5) == 0;
      if (($urandom % 3) == 0) r_off = 12'($urandom);
      else r_off = 12'($urandom_range(0, 40)) - 12'd20;
      apply(r_st, r_br, r_off, r_hl, r_sl);
      cmp_models($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
